// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, divider FSM states and the
// quotient value reported for a divide by zero.
package alu_pkg;

  localparam int ALU_W = 8;

  localparam logic [ALU_W-1:0] DZ_QUO = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/sub_9bit.sv
// Combinational 9-bit ripple subtractor (a - b as a + ~b + 1) used for the
// divider's trial subtraction; borrow is the inverted carry out.
module sub_9bit (
  input  logic [8:0] a,
  input  logic [8:0] b,
  output logic [8:0] diff,
  output logic       borrow
);

  logic [9:0] sum;

  assign sum    = {1'b0, a} + {1'b0, ~b} + 10'd1;
  assign diff   = sum[8:0];
  assign borrow = ~sum[9];

endmodule

// File: rtl/div_8bit_seq.sv
// Sequential 8-bit unsigned restoring divider: one subtract-and-shift per
// clock, start/busy/done handshake, registered quotient/remainder/dz.
module div_8bit_seq
  import alu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] quo_o,
  output logic [ALU_W-1:0] rem_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             dz_o
);

  div_state_t       state_q, state_d;
  logic [ALU_W-1:0] b_q, q_q, r_q;
  logic [2:0]       cnt_q;
  logic [ALU_W-1:0] quo_q, rem_q;
  logic             dz_q;

  logic [8:0]       trial;
  logic             trial_borrow;
  logic             trial_unused;
  logic [ALU_W-1:0] q_nxt, r_nxt;
  logic             accept;

  sub_9bit u_sub (
    .a      ({r_q, q_q[7]}),
    .b      ({1'b0, b_q}),
    .diff   (trial),
    .borrow (trial_borrow)
  );

  // With r < b the trial result always fits in 8 bits when it does not borrow.
  assign trial_unused = trial[8];

  always_comb begin
    r_nxt = trial_borrow ? {r_q[6:0], q_q[7]} : trial[7:0];
    q_nxt = {q_q[6:0], ~trial_borrow};
  end

  assign accept = start_i && (state_q != CALC);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) state_d = (b == '0) ? DONE : CALC;
        else         state_d = IDLE;
      end
      CALC:    if (cnt_q == 3'd7) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      b_q   <= '0;
      q_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dz_q  <= 1'b0;
    end else if (accept) begin
      if (b == '0) begin
        quo_q <= DZ_QUO;
        rem_q <= a;
        dz_q  <= 1'b1;
      end else begin
        b_q   <= b;
        q_q   <= a;
        r_q   <= '0;
        cnt_q <= '0;
      end
    end else if (state_q == CALC) begin
      q_q   <= q_nxt;
      r_q   <= r_nxt;
      cnt_q <= cnt_q + 3'd1;
      // Final iteration: publish the result in the same edge that enters DONE.
      if (cnt_q == 3'd7) begin
        quo_q <= q_nxt;
        rem_q <= r_nxt;
        dz_q  <= 1'b0;
      end
    end
  end

  assign quo_o  = quo_q;
  assign rem_o  = rem_q;
  assign dz_o   = dz_q;
  assign busy_o = (state_q == CALC);
  assign done_o = (state_q == DONE);

endmodule
